// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART-FIFO-side handshake bundle for uart_tx_arbiter.
// The arbiter connects through the slave modport, the requesters/FIFO side through master.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 11
);
    localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            lock;
    logic [NUM_REQ*DATA_WIDTH-1:0] data;
    logic [NUM_REQ-1:0]            ack;
    logic                          writeReq;
    logic                          writeAck;
    logic [DATA_WIDTH-1:0]         dataIn;
    logic [GW-1:0]                 grant;
    logic                          busy;

    modport slave (
        input  req, lock, data, writeAck,
        output ack, writeReq, dataIn, grant, busy
    );

    modport master (
        output req, lock, data, writeAck,
        input  ack, writeReq, dataIn, grant, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with per-requester lock and lock timeout, sharing the single
// UART transmit-FIFO write port among NUM_REQ requesters.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned DATA_WIDTH   = 11,
    parameter int unsigned LOCK_TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    uart_tx_arbiter_if.slave        bus
);
    localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CW = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t                  r_state;
    logic [NUM_REQ-1:0]      r_ack;
    logic                    r_write_req;
    logic [DATA_WIDTH-1:0]   r_data_in;
    logic [GW-1:0]           r_grant;
    logic                    r_busy;
    logic [GW-1:0]           r_rr_ptr;
    logic                    r_lock_vld;
    logic [GW-1:0]           r_lock_own;
    logic [CW-1:0]           r_cnt;

    logic                    w_pick_vld;
    logic [GW-1:0]           w_pick_idx;
    logic [GW-1:0]           w_next_ptr;
    logic [DATA_WIDTH-1:0]   w_pick_data;

    assign bus.ack      = r_ack;
    assign bus.writeReq = r_write_req;
    assign bus.dataIn   = r_data_in;
    assign bus.grant    = r_grant;
    assign bus.busy     = r_busy;

    // Winner selection: a live lock pins the port to its owner, otherwise the first
    // requester at or after the round-robin pointer wins (descending scan, nearest last).
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int unsigned slot;
            slot = (int'(r_rr_ptr) + k) % NUM_REQ;
            if (bus.req[GW'(slot)]) begin
                w_pick_vld = 1'b1;
                w_pick_idx = GW'(slot);
            end
        end
        if (r_lock_vld) begin
            w_pick_vld = bus.req[r_lock_own];
            w_pick_idx = r_lock_own;
        end
    end

    always_comb begin
        w_pick_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick_idx == GW'(i)) begin
                w_pick_data = bus.data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_next_ptr = (w_pick_idx == GW'(NUM_REQ - 1)) ? '0 : w_pick_idx + GW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ack       <= '0;
            r_write_req <= 1'b0;
            r_data_in   <= '0;
            r_grant     <= '0;
            r_busy      <= 1'b0;
            r_rr_ptr    <= '0;
            r_lock_vld  <= 1'b0;
            r_lock_own  <= '0;
            r_cnt       <= '0;
        end else begin
            r_ack <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_pick_vld) begin
                        r_grant     <= w_pick_idx;
                        r_data_in   <= w_pick_data;
                        r_write_req <= 1'b1;
                        r_busy      <= 1'b1;
                        r_rr_ptr    <= w_next_ptr;
                        r_state     <= S_GRANT;
                    end else if (r_lock_vld) begin
                        // Owner idle while holding the lock: age it out after LOCK_TIMEOUT cycles.
                        if (r_cnt == CW'(LOCK_TIMEOUT - 1)) begin
                            r_lock_vld <= 1'b0;
                            r_cnt      <= '0;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                S_GRANT: begin
                    if (bus.writeAck) begin
                        r_write_req <= 1'b0;
                        r_ack       <= NUM_REQ'(1) << r_grant;
                        r_lock_vld  <= bus.lock[r_grant];
                        r_lock_own  <= r_grant;
                        r_cnt       <= '0;
                        r_state     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_write_req <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end
endmodule
